// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit: operations, FSM states
// and the fill-mask helper used by the left-shift step.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REV_IN  = 3'd1,
    SHIFT   = 3'd2,
    REV_OUT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned DATA_W = 64;

  // Low k bits set; k never exceeds 32 so the shift cannot wrap.
  function automatic logic [63:0] low_mask(input logic [6:0] k);
    low_mask = (64'd1 << k) - 64'd1;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_reverser.sv
// Conditional 64-bit bit reverser shared by the entry and exit steps of right shifts.
module reverser_64 (
  input  logic        right,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  // Mirror bit order only when a right-shift reversal step is active.
  always_comb begin
    dout = din;
    if (right) begin
      for (int i = 0; i < 64; i++) begin
        dout[i] = din[63-i];
      end
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 64-bit shifter: right shifts are reverse -> iterative left shift -> reverse,
// so a single left-shift step and one reverser serve SLL, SRL and SRA.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 8,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [63:0]      req_data,
  input  logic [5:0]       req_shamt,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  state_t             state_r, state_nxt_s;
  op_t                op_r, op_nxt_s;
  logic [63:0]        work_r, work_nxt_s;
  logic [5:0]         rem_r, rem_nxt_s;
  logic               fill_r, fill_nxt_s;
  logic [TAG_W-1:0]   tag_r, tag_nxt_s;
  logic [63:0]        rev_s;
  logic               right_s;
  logic [6:0]         k_s;
  logic [63:0]        shifted_s;

  logic               rsp_valid_r, rsp_err_r, req_ready_r, busy_r;
  logic [63:0]        rsp_data_r;
  logic [TAG_W-1:0]   rsp_tag_r;

  assign right_s = (state_r == REV_IN) || (state_r == REV_OUT);

  reverser_64 u_rev (
    .right (right_s),
    .din   (work_r),
    .dout  (rev_s)
  );

  // One left-shift step of up to STEP positions, back-filling with the SRA sign.
  always_comb begin
    k_s       = STEP;
    shifted_s = 64'd0;
    if ({1'b0, rem_r} < STEP) begin
      k_s = {1'b0, rem_r};
    end else begin
      k_s = STEP;
    end
    if (fill_r) begin
      shifted_s = (work_r << k_s) | low_mask(k_s);
    end else begin
      shifted_s = work_r << k_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s = state_r;
    work_nxt_s  = work_r;
    rem_nxt_s   = rem_r;
    fill_nxt_s  = fill_r;
    op_nxt_s    = op_r;
    tag_nxt_s   = tag_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          work_nxt_s = req_data;
          rem_nxt_s  = req_shamt;
          op_nxt_s   = op_t'(req_op);
          tag_nxt_s  = req_tag;
          fill_nxt_s = (req_op == OP_SRA) ? req_data[63] : 1'b0;
          if ((req_shamt == 6'd0) || (req_op == OP_ILL)) begin
            state_nxt_s = DONE;
          end else if (req_op == OP_SLL) begin
            state_nxt_s = SHIFT;
          end else begin
            state_nxt_s = REV_IN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REV_IN: begin
        work_nxt_s  = rev_s;
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        work_nxt_s = shifted_s;
        rem_nxt_s  = rem_r - k_s[5:0];
        if (k_s == {1'b0, rem_r}) begin
          if (op_r == OP_SLL) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = REV_OUT;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      REV_OUT: begin
        work_nxt_s  = rev_s;
        state_nxt_s = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= OP_SLL;
      work_r  <= 64'd0;
      rem_r   <= 6'd0;
      fill_r  <= 1'b0;
      tag_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      work_r  <= work_nxt_s;
      rem_r   <= rem_nxt_s;
      fill_r  <= fill_nxt_s;
      tag_r   <= tag_nxt_s;
    end
  end

  // Registered handshake/status outputs; response payload captured once on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_data_r  <= 64'd0;
      rsp_tag_r   <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= (state_nxt_s == DONE);
      req_ready_r <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
      if ((state_r != DONE) && (state_nxt_s == DONE)) begin
        rsp_data_r <= work_nxt_s;
        rsp_tag_r  <= tag_nxt_s;
        rsp_err_r  <= (op_nxt_s == OP_ILL);
      end else begin
        rsp_data_r <= rsp_data_r;
        rsp_tag_r  <= rsp_tag_r;
        rsp_err_r  <= rsp_err_r;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_tag   = rsp_tag_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed requests with literal expectations
// plus a per-cycle comparison against an arithmetic model of result and latency.
module tb_shift_seq_ctrl;

  localparam int STEP  = 8;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [63:0]      req_data;
  logic [5:0]       req_shamt;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic             in_flight = 1'b0;
  int               acc_cyc   = 0;
  int               exp_lat   = 0;
  logic [63:0]      exp_data  = 64'd0;
  logic [TAG_W-1:0] exp_tag   = '0;
  logic             exp_err   = 1'b0;

  shift_seq_ctrl #(.SHIFT_STEP(STEP), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_data(input logic [1:0] op, input logic [63:0] d,
                                             input logic [5:0] sh);
    logic signed [63:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return sd >>> sh;
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [5:0] sh);
    int n;
    if (sh == 6'd0 || op == 2'b11) return 1;
    n = (int'(sh) + STEP - 1) / STEP;
    return (op == 2'b00) ? n + 1 : n + 3;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (in_flight) begin
        e = cyc - acc_cyc + 1;
        check("busy_in_flight", 64'(busy), 64'd1);
        check("req_ready_in_flight", 64'(req_ready), 64'd0);
        if (e < exp_lat) begin
          check("rsp_valid_early", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_valid_due", 64'(rsp_valid), 64'd1);
          check("rsp_data_model", rsp_data, exp_data);
          check("rsp_tag_model", 64'(rsp_tag), 64'(exp_tag));
          check("rsp_err_model", 64'(rsp_err), 64'(exp_err));
        end
      end else begin
        check("idle_req_ready", 64'(req_ready), 64'd1);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
      end
    end
  end

  task automatic accept(input logic [1:0] op, input logic [63:0] d, input logic [5:0] sh,
                        input logic [TAG_W-1:0] tag, input logic rdy);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_shamt = sh;
    req_tag   = tag;
    rsp_ready = rdy;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    exp_data  = model_data(op, d, sh);
    exp_lat   = model_lat(op, sh);
    exp_tag   = tag;
    exp_err   = (op == 2'b11);
    in_flight = 1'b1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [63:0] d, input logic [5:0] sh,
                        input logic [TAG_W-1:0] tag, input int stall,
                        input logic [63:0] lit_data, input int lit_lat, input logic lit_err);
    logic got;
    accept(op, d, sh, tag, (stall == 0));
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      check("rsp_timeout", 64'd0, 64'd1);
      in_flight = 1'b0;
    end else begin
      check("lit_latency", 64'(cyc - acc_cyc + 1), 64'(lit_lat));
      check("lit_data", rsp_data, lit_data);
      check("lit_tag", 64'(rsp_tag), 64'(tag));
      check("lit_err", 64'(rsp_err), 64'(lit_err));
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        check("stall_data_held", rsp_data, lit_data);
        rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      in_flight = 1'b0;
      check("post_hs_valid", 64'(rsp_valid), 64'd0);
      check("post_hs_ready", 64'(req_ready), 64'd1);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 64'd0;
    req_shamt = 6'd0;
    req_tag   = '0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(2'b00, 64'h1, 6'd20, 4'hA, 0, 64'h0000_0000_0010_0000, 4, 1'b0);
    do_req(2'b01, 64'h8000_0000_0000_0000, 6'd63, 4'h3, 0, 64'h1, 11, 1'b0);
    do_req(2'b10, 64'h8000_0000_0000_00F0, 6'd4, 4'h4, 0, 64'hF800_0000_0000_000F, 4, 1'b0);
    do_req(2'b01, 64'h8000_0000_0000_00F0, 6'd4, 4'h5, 0, 64'h0800_0000_0000_000F, 4, 1'b0);
    do_req(2'b10, 64'hDEAD_BEEF_0123_4567, 6'd0, 4'h6, 0, 64'hDEAD_BEEF_0123_4567, 1, 1'b0);
    do_req(2'b11, 64'hDEAD_BEEF_0123_4567, 6'd5, 4'h7, 0, 64'hDEAD_BEEF_0123_4567, 1, 1'b1);
    do_req(2'b10, 64'hF000_0000_0000_0000, 6'd63, 4'h8, 0, 64'hFFFF_FFFF_FFFF_FFFF, 11, 1'b0);
    do_req(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 4'h9, 0, 64'h8000_0000_0000_0000, 9, 1'b0);
    do_req(2'b01, 64'h0123_4567_89AB_CDEF, 6'd16, 4'hB, 0, 64'h0000_0123_4567_89AB, 5, 1'b0);
    do_req(2'b00, 64'h0123_4567_89AB_CDEF, 6'd9, 4'hC, 0, 64'h468A_CF13_579B_DE00, 3, 1'b0);
    do_req(2'b00, 64'h3, 6'd8, 4'hD, 5, 64'h300, 2, 1'b0);

    // Reset while SHIFT is in progress must clear outputs without a clock edge.
    accept(2'b00, 64'h1, 6'd63, 4'hE, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    in_flight = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    do_req(2'b10, 64'h0000_0000_0000_0100, 6'd8, 4'hF, 0, 64'h1, 4, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
